gfx_shader_wb_arbiter_n: RTL and testbench

// - N-input writeback arbiter for the shader back end; merges per-pipe writeback

---
 rtl/gfx_shader_wb_arbiter_n.sv | 127 ++++++++++++
 tb/tb_gfx_shader_wb_arbiter_n.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_shader_wb_arbiter_n.sv
// N-input writeback arbiter: optional fixed-priority port 0, round-robin over the rest,
// one registered output stage. Define GFX_WB_ARB_STARVE_EN for per-port starvation forcing.
module gfx_shader_wb_arbiter_n #(
  parameter int PORTS        = 4,
  parameter int DATA_W       = 64,
  parameter int PRIO_PORT0   = 1,
  parameter int STARVE_LIMIT = 15,
  localparam int PW          = $clog2(PORTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS-1:0]             in_valid,
  output logic [PORTS-1:0]             in_ready,
  input  logic [PORTS-1:0][DATA_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [PW-1:0]                out_port
);

  localparam logic [PW-1:0] RR_FIRST = (PRIO_PORT0 != 0) ? PW'(1) : PW'(0);
  localparam logic [PW-1:0] LAST     = PW'(PORTS - 1);
  localparam logic [PW:0]   PORTS_W  = (PW + 1)'(PORTS);

  if (PORTS < 2 || PORTS > 16 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("gfx_shader_wb_arbiter_n: PORTS must be 2..16 and STARVE_LIMIT >= 1");
  end

  logic                 load;
  logic [PORTS-1:0]     grant;
  logic [PW-1:0]        grant_idx;
  logic                 grant_any;
  logic                 grant_rr;
  logic [PW-1:0]        rr_ptr_reg;
  logic [PW-1:0]        rr_next;
  logic [PW:0]          rr_sum;
  logic [PW-1:0]        rr_idx;
  logic                 out_valid_reg;
  logic [DATA_W-1:0]    out_data_reg;
  logic [PW-1:0]        out_port_reg;

  assign load      = ~out_valid_reg | out_ready;
  assign in_ready  = (load && !rst) ? grant : '0;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_port  = out_port_reg;

`ifdef GFX_WB_ARB_STARVE_EN
  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [PORTS-1:0] starved;

  // Counts cycles a port has been refused; an idle or just-served port starts over.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_starve
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst || !in_valid[gi] || in_ready[gi]) begin
        cnt_reg <= '0;
      end else if (cnt_reg != LIMIT) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end

    assign starved[gi] = (cnt_reg == LIMIT);
  end
`endif

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    grant_rr  = 1'b0;
    rr_sum    = '0;
    rr_idx    = '0;
`ifdef GFX_WB_ARB_STARVE_EN
    for (int i = 0; i < PORTS; i++) begin
      if (!grant_any && starved[i]) begin
        grant[i]  = 1'b1;
        grant_idx = PW'(i);
        grant_any = 1'b1;
      end
    end
`endif
    if (!grant_any && PRIO_PORT0 != 0 && in_valid[0]) begin
      grant[0]  = 1'b1;
      grant_any = 1'b1;
    end
    // Scan forward from rr_ptr with wrap; the priority port never takes a round-robin slot.
    for (int off = 0; off < PORTS; off++) begin
      rr_sum = {1'b0, rr_ptr_reg} + (PW + 1)'(off);
      if (rr_sum >= PORTS_W) rr_sum = rr_sum - PORTS_W;
      rr_idx = rr_sum[PW-1:0];
      if (!grant_any && in_valid[rr_idx] && !(PRIO_PORT0 != 0 && rr_idx == '0)) begin
        grant[rr_idx] = 1'b1;
        grant_idx     = rr_idx;
        grant_any     = 1'b1;
        grant_rr      = 1'b1;
      end
    end
  end

  assign rr_next = (grant_idx == LAST) ? RR_FIRST : grant_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= RR_FIRST;
    end else if (load) begin
      out_valid_reg <= grant_any;
      if (grant_any) begin
        out_data_reg <= in_data[grant_idx];
        out_port_reg <= grant_idx;
      end
      if (grant_any && grant_rr) begin
        rr_ptr_reg <= rr_next;
      end
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant));
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid_reg && !out_ready) |=>
      (out_valid_reg && $stable(out_data_reg) && $stable(out_port_reg)));

endmodule

// File: tb/tb_gfx_shader_wb_arbiter_n.sv
// Scoreboard bench for gfx_shader_wb_arbiter_n (PORTS=4, PRIO_PORT0=1, STARVE_LIMIT=3).
// Expected (port, data) pairs are queued when a grant is predicted and popped on drain.
module tb_gfx_shader_wb_arbiter_n;

  localparam int PORTS  = 4;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [1:0]        port;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [PORTS-1:0]             in_valid;
  logic [PORTS-1:0]             in_ready;
  logic [PORTS-1:0][DATA_W-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            out_data;
  logic [1:0]                   out_port;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  gfx_shader_wb_arbiter_n #(
    .PORTS(PORTS), .DATA_W(DATA_W), .PRIO_PORT0(1), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Every drained output is compared against the oldest predicted transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected: got port %0d data %h, want no output", out_port, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_port !== mon_e.port || out_data !== mon_e.data) begin
          errors++;
          $display("FAIL drain: got port %0d data %h, want port %0d data %h",
                   out_port, out_data, mon_e.port, mon_e.data);
        end else begin
          $display("drain port %0d data %h", out_port, out_data);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < PORTS; i++) in_data[i] = {$urandom, $urandom};
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '1;
    out_ready = 1'b0;
    randomize_data();
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    next_cycle();
    rst = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_single();
    in_valid = 4'b0100;
    in_data[2] = 64'hABCD;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b want 0100", in_ready);
    end
    exp_q.push_back('{port: 2'd2, data: 64'hABCD});
    next_cycle();
    in_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got out_valid %b want 1", out_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_clear: got out_valid %b want 0", out_valid);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [1:0] p;
    logic [3:0] want;
    apply_reset();
    in_valid = 4'b1110;
    for (int k = 0; k < 9; k++) begin
      randomize_data();
      p = 2'(1 + k % 3);
      want = 4'(1 << p);
      @(negedge clk);
      checks++;
      if (in_ready !== want) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, in_ready, want);
      end
      exp_q.push_back('{port: p, data: in_data[p]});
      next_cycle();
    end
    in_valid = '0;
    next_cycle();
  endtask

  task automatic test_priority();
    in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      randomize_data();
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0001) begin
        errors++;
        $display("FAIL prio_port0[%0d]: got %b want 0001", k, in_ready);
      end
      exp_q.push_back('{port: 2'd0, data: in_data[0]});
      next_cycle();
    end
    in_valid = 4'b1000;
    randomize_data();
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL prio_port3_after: got %b want 1000", in_ready);
    end
    exp_q.push_back('{port: 2'd3, data: in_data[3]});
    next_cycle();
    in_valid = '0;
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    randomize_data();
    held = in_data[2];
    in_valid = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_first: got %b want 0100", in_ready);
    end
    exp_q.push_back('{port: 2'd2, data: held});
    next_cycle();
    out_ready = 1'b0;
    in_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      randomize_data();
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got ready %b valid %b want 0000 1", k, in_ready, out_valid);
      end
      checks++;
      if (out_data !== held || out_port !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got port %0d data %h want port 2 data %h",
                 k, out_port, out_data, held);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release: got %b want 0010", in_ready);
    end
    exp_q.push_back('{port: 2'd1, data: in_data[1]});
    next_cycle();
    in_valid = '0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    randomize_data();
    in_valid = 4'b1110;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mid_first: got %b want 0010", in_ready);
    end
    exp_q.push_back('{port: 2'd1, data: in_data[1]});
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_ready: got %b want 0000", in_ready);
    end
    next_cycle();
    rst = 1'b0;
    exp_q.delete();
    randomize_data();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard: got out_valid %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mid_rr_ptr: got %b want 0010", in_ready);
    end
    exp_q.push_back('{port: 2'd1, data: in_data[1]});
    next_cycle();
    in_valid = '0;
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [3:0] want;
    apply_reset();
    in_valid = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      randomize_data();
`ifdef GFX_WB_ARB_STARVE_EN
      want = (k % 4 == 3) ? 4'b0010 : 4'b0001;
`else
      want = 4'b0001;
`endif
      @(negedge clk);
      checks++;
      if (in_ready !== want) begin
        errors++;
        $display("FAIL starve[%0d]: got %b want %b", k, in_ready, want);
      end
      if (want == 4'b0010) exp_q.push_back('{port: 2'd1, data: in_data[1]});
      else                 exp_q.push_back('{port: 2'd0, data: in_data[0]});
      next_cycle();
    end
    in_valid = '0;
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    in_data = '0;
    next_cycle();
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_backpressure();
    test_reset_mid();
    test_starvation();
    next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
